// File: rtl/ls95_deser_if.sv
// ls95_deser_if: serial-link inputs and word handshake for the ls95 deserializer.
// The master side drives the bit stream and handshake; the slave side is the receiver.
interface ls95_deser_if #(
    parameter int WIDTH = 4
);
    logic             shift_en;
    logic             sdi;
    logic             sync;
    logic             ack;
    logic             clr_err;
    logic [WIDTH-1:0] q;
    logic             valid;
    logic             busy;
    logic             ovr;
    logic             ferr;

    modport master (
        output shift_en, sdi, sync, ack, clr_err,
        input  q, valid, busy, ovr, ferr
    );

    modport slave (
        input  shift_en, sdi, sync, ack, clr_err,
        output q, valid, busy, ovr, ferr
    );
endinterface

// File: rtl/ls95_deser.sv
// ls95_deser: reassembles a framed ls95 QD bit stream into WIDTH-bit words.
// The first bit of a word lands in q[WIDTH-1]; completed words use valid/ack.
module ls95_deser #(
    parameter int WIDTH = 4
) (
    input  logic            clk_i,
    input  logic            clr_n_i,
    ls95_deser_if.slave     bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {HUNT, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-2:0] sr_q, sr_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             ovr_q, ovr_d;
    logic             ferr_q, ferr_d;
    logic             done;
    logic [WIDTH-1:0] word;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        q_d     = q_q;
        valid_d = valid_q;
        ovr_d   = ovr_q & ~bus.clr_err;
        ferr_d  = ferr_q & ~bus.clr_err;
        done    = 1'b0;
        word    = {sr_q, bus.sdi};

        if (bus.shift_en) begin
            unique case (state_q)
                HUNT: begin
                    if (bus.sync) begin
                        sr_d    = (WIDTH-1)'(bus.sdi);
                        cnt_d   = CW'(1);
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.sync && cnt_q != '0) begin
                        ferr_d = 1'b1;
                        sr_d   = (WIDTH-1)'(bus.sdi);
                        cnt_d  = CW'(1);
                    end else if (cnt_q == '0) begin
                        sr_d  = (WIDTH-1)'(bus.sdi);
                        cnt_d = CW'(1);
                    end else if (cnt_q == LAST) begin
                        done  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        sr_d  = (WIDTH-1)'({sr_q, bus.sdi});
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (bus.ack && valid_q)
            valid_d = 1'b0;

        // A completing word may replace q only if the old word is gone or acked now
        if (done) begin
            if (!valid_q || bus.ack) begin
                q_d     = word;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end

        busy_d = (state_d == SHIFT) && (cnt_d != '0);
    end

    always_ff @(posedge clk_i) begin
        if (!clr_n_i) begin
            state_q <= HUNT;
            cnt_q   <= '0;
            sr_q    <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign bus.q     = q_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.ovr   = ovr_q;
    assign bus.ferr  = ferr_q;
endmodule

// File: tb/tb_ls95_deser.sv
// tb_ls95_deser: directed scenarios for the ls95 deserializer, WIDTH=4.
// Each task drives its scenario and compares outputs against hand-derived values.
module tb_ls95_deser;
    logic clk = 1'b0;
    logic clr_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ls95_deser_if #(.WIDTH(4)) bus ();

    ls95_deser #(.WIDTH(4)) dut (
        .clk_i   (clk),
        .clr_n_i (clr_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic s);
        bus.shift_en = 1'b1;
        bus.sdi      = b;
        bus.sync     = s;
        step();
        bus.shift_en = 1'b0;
        bus.sync     = 1'b0;
        bus.sdi      = 1'b0;
    endtask

    task automatic do_ack();
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.shift_en = 1'($urandom_range(0, 1));
            bus.sync     = 1'($urandom_range(0, 1));
            bus.sdi      = 1'($urandom_range(0, 1));
            step();
            checks++;
            if (bus.q !== 4'b0000 || bus.valid !== 1'b0 || bus.busy !== 1'b0
                || bus.ovr !== 1'b0 || bus.ferr !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d]: q=%b v=%b b=%b o=%b f=%b, want all 0",
                         i, bus.q, bus.valid, bus.busy, bus.ovr, bus.ferr);
            end
        end
        bus.shift_en = 1'b0;
        bus.sync     = 1'b0;
        bus.sdi      = 1'b0;
        clr_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        send_bit(1'b1, 1'b1);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy1: got %b want 1", bus.busy);
        end
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        checks++;
        if (bus.busy !== 1'b1 || bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_mid: busy=%b valid=%b want 1 0", bus.busy, bus.valid);
        end
        send_bit(1'b1, 1'b0);
        checks++;
        if (bus.q !== 4'b1011 || bus.valid !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_word: q=%b v=%b b=%b want 1011 1 0",
                     bus.q, bus.valid, bus.busy);
        end
        do_ack();
        checks++;
        if (bus.valid !== 1'b0 || bus.q !== 4'b1011) begin
            errors++;
            $display("FAIL basic_ack: v=%b q=%b want 0 1011", bus.valid, bus.q);
        end
    endtask

    task automatic test_hunt_gapped();
        logic [3:0] w;
        w = 4'b0110;
        clr_n = 1'b0;
        step();
        clr_n = 1'b1;
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        checks++;
        if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL hunt_ignore: busy=%b valid=%b want 0 0", bus.busy, bus.valid);
        end
        for (int i = 3; i >= 0; i--) begin
            send_bit(w[i], (i == 3));
            if (i != 0) begin
                step();
                step();
            end
            if (i == 2) begin
                checks++;
                if (bus.busy !== 1'b1 || bus.valid !== 1'b0) begin
                    errors++;
                    $display("FAIL gap_hold: busy=%b valid=%b want 1 0",
                             bus.busy, bus.valid);
                end
            end
        end
        checks++;
        if (bus.q !== 4'b0110 || bus.valid !== 1'b1 || bus.ovr !== 1'b0
            || bus.ferr !== 1'b0) begin
            errors++;
            $display("FAIL gapped_word: q=%b v=%b o=%b f=%b want 0110 1 0 0",
                     bus.q, bus.valid, bus.ovr, bus.ferr);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] bits;
        bits = 8'b1011_0101;
        do_ack();
        for (int i = 7; i >= 0; i--) send_bit(bits[i], (i == 7));
        checks++;
        if (bus.q !== 4'b1011 || bus.valid !== 1'b1 || bus.ovr !== 1'b1) begin
            errors++;
            $display("FAIL overrun: q=%b v=%b o=%b want 1011 1 1",
                     bus.q, bus.valid, bus.ovr);
        end
        bus.clr_err = 1'b1;
        step();
        bus.clr_err = 1'b0;
        checks++;
        if (bus.ovr !== 1'b0 || bus.q !== 4'b1011) begin
            errors++;
            $display("FAIL clr_err: o=%b q=%b want 0 1011", bus.ovr, bus.q);
        end
    endtask

    task automatic test_framing();
        do_ack();
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        checks++;
        if (bus.ferr !== 1'b1 || bus.valid !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL ferr_set: f=%b v=%b b=%b want 1 0 1",
                     bus.ferr, bus.valid, bus.busy);
        end
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        checks++;
        if (bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL ferr_early_valid: v=%b want 0", bus.valid);
        end
        send_bit(1'b0, 1'b0);
        checks++;
        if (bus.q !== 4'b0110 || bus.valid !== 1'b1 || bus.ferr !== 1'b1
            || bus.ovr !== 1'b0) begin
            errors++;
            $display("FAIL ferr_word: q=%b v=%b f=%b o=%b want 0110 1 1 0",
                     bus.q, bus.valid, bus.ferr, bus.ovr);
        end
    endtask

    task automatic test_coincident_ack();
        logic [3:0] a;
        logic [3:0] b;
        a = 4'b1011;
        b = 4'b1100;
        do_ack();
        for (int i = 3; i >= 0; i--) send_bit(a[i], (i == 3));
        checks++;
        if (bus.q !== 4'b1011 || bus.valid !== 1'b1) begin
            errors++;
            $display("FAIL coinc_setup: q=%b v=%b want 1011 1", bus.q, bus.valid);
        end
        for (int i = 3; i >= 1; i--) send_bit(b[i], 1'b0);
        bus.ack = 1'b1;
        send_bit(b[0], 1'b0);
        bus.ack = 1'b0;
        checks++;
        if (bus.q !== 4'b1100 || bus.valid !== 1'b1 || bus.ovr !== 1'b0) begin
            errors++;
            $display("FAIL coinc_ack: q=%b v=%b o=%b want 1100 1 0",
                     bus.q, bus.valid, bus.ovr);
        end
    endtask

    task automatic test_reset_midword();
        logic [3:0] w;
        w = 4'b1001;
        do_ack();
        send_bit(1'b1, 1'b1);
        clr_n = 1'b0;
        send_bit(1'b0, 1'b0);
        clr_n = 1'b1;
        checks++;
        if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.ferr !== 1'b0
            || bus.q !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset: b=%b v=%b f=%b q=%b want 0 0 0 0000",
                     bus.busy, bus.valid, bus.ferr, bus.q);
        end
        for (int i = 3; i >= 0; i--) send_bit(w[i], (i == 3));
        checks++;
        if (bus.q !== 4'b1001 || bus.valid !== 1'b1 || bus.ferr !== 1'b0
            || bus.ovr !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_word: q=%b v=%b f=%b o=%b want 1001 1 0 0",
                     bus.q, bus.valid, bus.ferr, bus.ovr);
        end
    endtask

    task automatic test_clr_err_collision();
        logic [3:0] w;
        w = 4'b0011;
        for (int i = 3; i >= 1; i--) send_bit(w[i], 1'b0);
        bus.clr_err = 1'b1;
        send_bit(w[0], 1'b0);
        bus.clr_err = 1'b0;
        checks++;
        if (bus.ovr !== 1'b1 || bus.q !== 4'b1001 || bus.valid !== 1'b1) begin
            errors++;
            $display("FAIL clr_collide: o=%b q=%b v=%b want 1 1001 1",
                     bus.ovr, bus.q, bus.valid);
        end
    endtask

    initial begin
        bus.shift_en = 1'b0;
        bus.sdi      = 1'b0;
        bus.sync     = 1'b0;
        bus.ack      = 1'b0;
        bus.clr_err  = 1'b0;
        test_reset();
        test_basic();
        test_hunt_gapped();
        test_overrun();
        test_framing();
        test_coincident_ack();
        test_reset_midword();
        test_clr_err_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
